// File: rtl/up2_pkg.sv
// Shared types and constants for the up2 board UART receive path.
package up2_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/up2_sync.sv
// N-flop synchroniser for an asynchronous level input; flops reset to 1 (line idle).
module up2_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] ff;

  // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) ff <= '1;
    else     ff <= {ff[N-2:0], d};
  end

  assign q = ff[N-1];

endmodule

// File: rtl/up2_uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, valid/ready byte output, framing/overrun pulses.
module up2_uart_rx
  import up2_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [TW-1:0] HALF     = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] LAST     = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(UART_DATA_BITS - 1);

  logic                      rx_s;
  uart_rx_state_t            state;
  logic [TW-1:0]             timer;
  logic [BW-1:0]             bit_idx;
  logic [UART_DATA_BITS-1:0] shift;

  up2_sync #(.N(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shift register is plain flops, not a memory, so it is reset along with everything else.
      state     <= IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // NOTE: a commit later in this block overrides this clear; the last non-blocking assignment wins.
      if (valid && ready) valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            timer <= '0;
            state <= START;
          end
        end
        START: begin
          if (timer == HALF) begin
            timer   <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (timer == LAST) begin
            timer <= '0;
            shift <= {rx_s, shift[UART_DATA_BITS-1:1]};
            if (bit_idx == LAST_BIT) state   <= STOP;
            else                     bit_idx <= bit_idx + 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        STOP: begin
          if (timer == LAST) begin
            timer <= '0;
            if (rx_s) begin
              // Leaving mid stop bit lets the next start edge be caught back-to-back.
              state <= IDLE;
              if (!valid || ready) begin
                data  <= shift;
                valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_up2_uart_rx.sv
// Directed bench for up2_uart_rx at CLKS_PER_BIT=16, SYNC_STAGES=2.
module tb_up2_uart_rx;

  localparam int C = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;

  up2_uart_rx #(.CLKS_PER_BIT(C), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Passive observation of the output interface, sampled on the falling edge.
  int         cyc = 0;
  int         fe_cnt = 0, ov_cnt = 0, both_cnt = 0, rise_cnt = 0, acc_cnt = 0;
  int         rise_cyc = 0;
  logic [7:0] rise_data = '0, last_acc = '0;
  logic       valid_q = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (frame_err && overrun) both_cnt++;
    if (valid && !valid_q) begin
      rise_cnt++;
      rise_cyc  = cyc;
      rise_data = data;
    end
    if (valid && ready) begin
      acc_cnt++;
      last_acc = data;
    end
    valid_q = valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int frame_cyc = 0;

  // Drives one frame starting just after the next rising edge; leaves rx at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop_lvl);
    @(posedge clk); #1;
    frame_cyc = cyc;
    rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (C) @(posedge clk); #1;
      rx = b[i];
    end
    repeat (C) @(posedge clk); #1;
    rx = stop_lvl;
    repeat (C) @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int r0, f0, o0, a0;

  initial begin
    // Reset state
    idle(3);
    @(negedge clk);
    check("rst_data", 32'(data), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_ovr", 32'(overrun), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(5);

    // 1: single byte, consumer always ready
    ready = 1'b1;
    r0 = rise_cnt; f0 = fe_cnt; o0 = ov_cnt;
    send_frame(8'hA5, 1'b1);
    idle(20);
    check("t1_rises", 32'(rise_cnt - r0), 32'd1);
    check("t1_data", 32'(rise_data), 32'hA5);
    check("t1_latency", 32'(rise_cyc - frame_cyc), 32'd155);
    check("t1_ferr", 32'(fe_cnt - f0), 32'd0);
    check("t1_ovr", 32'(ov_cnt - o0), 32'd0);
    check("t1_valid_low", 32'(valid), 32'h0);

    // 2: back-to-back bytes with no consumer -> overrun on the second
    ready = 1'b0;
    r0 = rise_cnt; o0 = ov_cnt;
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    idle(50);
    check("t2_rises", 32'(rise_cnt - r0), 32'd1);
    check("t2_ovr", 32'(ov_cnt - o0), 32'd1);
    check("t2_valid_held", 32'(valid), 32'h1);
    check("t2_data_held", 32'(data), 32'h3C);
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    @(negedge clk);
    check("t2_valid_fall", 32'(valid), 32'h0);
    check("t2_data_kept", 32'(data), 32'h3C);
    check("t2_acc_data", 32'(last_acc), 32'h3C);

    // 3: stop bit low then held-low line -> exactly one frame error
    r0 = rise_cnt; f0 = fe_cnt;
    send_frame(8'h55, 1'b0);
    idle(64);
    check("t3_ferr_low", 32'(fe_cnt - f0), 32'd1);
    rx = 1'b1;
    idle(20);
    check("t3_ferr", 32'(fe_cnt - f0), 32'd1);
    check("t3_no_valid", 32'(rise_cnt - r0), 32'd0);
    check("t3_valid", 32'(valid), 32'h0);

    // 4: short glitch is rejected, next frame still received
    r0 = rise_cnt; f0 = fe_cnt;
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(30);
    check("t4_glitch_valid", 32'(rise_cnt - r0), 32'd0);
    check("t4_glitch_ferr", 32'(fe_cnt - f0), 32'd0);
    ready = 1'b1;
    send_frame(8'h81, 1'b1);
    idle(20);
    check("t4_rises", 32'(rise_cnt - r0), 32'd1);
    check("t4_data", 32'(rise_data), 32'h81);
    check("t4_ferr", 32'(fe_cnt - f0), 32'd0);

    // 5: reset during bit 4 of 0xF0 discards the frame
    r0 = rise_cnt;
    @(posedge clk); #1;
    rx = 1'b0;
    for (int i = 0; i < 4; i++) idle(C);
    idle(C);
    rx = 1'b1;
    idle(C / 2);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t5_rst_data", 32'(data), 32'h0);
    check("t5_rst_valid", 32'(valid), 32'h0);
    check("t5_rst_ferr", 32'(frame_err), 32'h0);
    check("t5_rst_ovr", 32'(overrun), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(4 * C + C);
    check("t5_aborted", 32'(rise_cnt - r0), 32'd0);
    send_frame(8'h0F, 1'b1);
    idle(20);
    check("t5_rises", 32'(rise_cnt - r0), 32'd1);
    check("t5_data", 32'(rise_data), 32'h0F);

    // 6: commit on the same edge the old byte is consumed
    ready = 1'b0;
    o0 = ov_cnt;
    send_frame(8'h11, 1'b1);
    idle(20);
    check("t6_first", 32'(data), 32'h11);
    a0 = acc_cnt;
    fork
      send_frame(8'h22, 1'b1);
      begin
        @(posedge clk);
        repeat (154) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
      end
    join
    idle(10);
    check("t6_acc_cnt", 32'(acc_cnt - a0), 32'd1);
    check("t6_acc_data", 32'(last_acc), 32'h11);
    check("t6_valid", 32'(valid), 32'h1);
    check("t6_data", 32'(data), 32'h22);
    check("t6_ovr", 32'(ov_cnt - o0), 32'd0);
    ready = 1'b1;
    idle(3);
    check("t6_drained", 32'(valid), 32'h0);
    check("never_both", 32'(both_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
